// File: rtl/aes128_inv_cipher_iter.sv
// Iterative AES-128 decryption core: on-chip key expansion, UNROLL inverse rounds
// per clock, valid/ready handshakes on both sides and optional CBC chaining.

module aes_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_y
);
  localparam logic [0:255][7:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  assign o_y = TABLE[i_a];
endmodule

module aes_inv_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_y
);
  localparam logic [0:255][7:0] TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};
  assign o_y = TABLE[i_a];
endmodule

module aes128_inv_cipher_iter #(
  parameter int UNROLL = 1,
  parameter bit CBC_EN = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_load,
  input  logic [127:0] key,
  output logic         key_ready,
  input  logic         iv_load,
  input  logic [127:0] iv,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
    $error("aes128_inv_cipher_iter: UNROLL must be 1, 2, 5 or 10");
  end

  typedef enum logic [2:0] {S_KEY_IDLE, S_EXPAND, S_IDLE, S_RUN, S_DONE} state_t;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] t;
    // Row r rotates right by r columns: out[r][c] = in[r][c-r].
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return t;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] t;
    logic [7:0]   a [4];
    logic [7:0]   m9 [4];
    logic [7:0]   mb [4];
    logic [7:0]   md [4];
    logic [7:0]   me [4];
    logic [7:0]   x2, x4, x8;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r]  = s[127-8*(4*c+r) -: 8];
        x2    = gf_xtime(a[r]);
        x4    = gf_xtime(x2);
        x8    = gf_xtime(x4);
        m9[r] = x8 ^ a[r];
        mb[r] = x8 ^ x2 ^ a[r];
        md[r] = x8 ^ x4 ^ a[r];
        me[r] = x8 ^ x4 ^ x2;
      end
      t[127-8*(4*c+0) -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      t[127-8*(4*c+1) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      t[127-8*(4*c+2) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      t[127-8*(4*c+3) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    return t;
  endfunction

  state_t       r_state;
  logic [127:0] r_rk [0:10];
  logic [3:0]   r_exp_cnt;
  logic [7:0]   r_rcon;
  logic [127:0] r_data;
  logic [127:0] r_ct_hold;
  logic [127:0] r_chain;
  logic [3:0]   r_round;
  logic         r_out_valid;
  logic [127:0] r_plaintext;

  // Forward key schedule: one round key per EXPAND cycle from the previous one.
  logic [127:0] w_prev_rk;
  logic [127:0] w_next_rk;
  logic [31:0]  w_rot;
  logic [31:0]  w_sub_word;
  logic [31:0]  w_temp;

  assign w_prev_rk = r_rk[r_exp_cnt - 4'd1];
  assign w_rot     = {w_prev_rk[23:0], w_prev_rk[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_key_sbox
    aes_sbox u_sbox (.i_a(w_rot[31-8*b -: 8]), .o_y(w_sub_word[31-8*b -: 8]));
  end

  assign w_temp              = w_sub_word ^ {r_rcon, 24'h0};
  assign w_next_rk[127:96]   = w_prev_rk[127:96] ^ w_temp;
  assign w_next_rk[95:64]    = w_prev_rk[95:64]  ^ w_next_rk[127:96];
  assign w_next_rk[63:32]    = w_prev_rk[63:32]  ^ w_next_rk[95:64];
  assign w_next_rk[31:0]     = w_prev_rk[31:0]   ^ w_next_rk[63:32];

  // Unrolled inverse rounds r_round, r_round-1, ... down to r_round-UNROLL+1.
  logic [127:0] w_stage [0:UNROLL];
  assign w_stage[0] = r_data;

  for (genvar u = 0; u < UNROLL; u++) begin : g_round
    logic [3:0]   w_rnd;
    logic [127:0] w_sub;
    logic [127:0] w_ark;
    assign w_rnd = r_round - 4'(u);
    for (genvar b = 0; b < 16; b++) begin : g_inv_sbox
      aes_inv_sbox u_inv_sbox (.i_a(w_stage[u][127-8*b -: 8]), .o_y(w_sub[127-8*b -: 8]));
    end
    assign w_ark          = inv_shift_rows(w_sub) ^ r_rk[w_rnd];
    assign w_stage[u + 1] = (w_rnd == 4'd0) ? w_ark : inv_mix_columns(w_ark);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_KEY_IDLE;
      // NOTE: the round-key array is reset explicitly; a reset must leave no
      // usable key behind, so it cannot be left to an uninitialised RAM.
      for (int i = 0; i < 11; i++) r_rk[i] <= '0;
      r_exp_cnt   <= 4'd1;
      r_rcon      <= 8'h01;
      r_data      <= '0;
      r_ct_hold   <= '0;
      r_chain     <= '0;
      r_round     <= 4'd9;
      r_out_valid <= 1'b0;
      r_plaintext <= '0;
    end else begin
      case (r_state)
        S_KEY_IDLE, S_IDLE: begin
          if (key_load) begin
            r_rk[0]   <= key;
            r_exp_cnt <= 4'd1;
            r_rcon    <= 8'h01;
            r_state   <= S_EXPAND;
          end else if (r_state == S_IDLE && in_valid) begin
            r_data    <= ciphertext ^ r_rk[10];
            r_ct_hold <= ciphertext;
            r_round   <= 4'd9;
            r_state   <= S_RUN;
          end
        end
        S_EXPAND: begin
          r_rk[r_exp_cnt] <= w_next_rk;
          r_rcon          <= gf_xtime(r_rcon);
          if (r_exp_cnt == 4'd10) r_state <= S_IDLE;
          else                    r_exp_cnt <= r_exp_cnt + 4'd1;
        end
        S_RUN: begin
          r_data <= w_stage[UNROLL];
          if (r_round == 4'(UNROLL - 1)) begin
            r_plaintext <= w_stage[UNROLL] ^ (CBC_EN ? r_chain : 128'h0);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_round <= r_round - 4'(UNROLL);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
            if (CBC_EN) r_chain <= r_ct_hold;
          end
        end
        default: r_state <= S_KEY_IDLE;
      endcase

      // A new IV loaded alongside a block accept is the one that block uses.
      if (CBC_EN && iv_load &&
          (r_state == S_KEY_IDLE || r_state == S_EXPAND || r_state == S_IDLE))
        r_chain <= iv;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign key_ready = (r_state == S_IDLE) || (r_state == S_RUN) || (r_state == S_DONE);
  assign out_valid = r_out_valid;
  assign plaintext = r_plaintext;

endmodule

// File: tb/tb_aes128_inv_cipher_iter.sv
// Directed bench: five cores (UNROLL 1/2/5/10 ECB, UNROLL 1 CBC) share stimulus and
// are checked against FIPS-197 and SP800-38A vectors, latencies and flow control.

module tb_aes128_inv_cipher_iter;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] IV_F   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_F1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] PT_F1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT_F2  = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] PT_F2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  logic         clk;
  logic         rst;
  logic         key_load;
  logic [127:0] key;
  logic         iv_load;
  logic [127:0] iv;
  logic         in_valid;
  logic [127:0] ciphertext;
  logic         out_ready;
  logic [4:0]   key_ready_v;
  logic [4:0]   in_ready_v;
  logic [4:0]   out_valid_v;
  logic [127:0] pt [5];

  int           n_checks = 0;
  int           n_pass   = 0;
  int           lat [5];
  logic [127:0] got [5];
  int           key_lat;
  logic         saw_ready;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    aes128_inv_cipher_iter #(
      .UNROLL ((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : (g == 3) ? 10 : 1),
      .CBC_EN (g == 4)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .key_load   (key_load),
      .key        (key),
      .key_ready  (key_ready_v[g]),
      .iv_load    (iv_load),
      .iv         (iv),
      .in_valid   (in_valid),
      .in_ready   (in_ready_v[g]),
      .ciphertext (ciphertext),
      .out_valid  (out_valid_v[g]),
      .out_ready  (out_ready),
      .plaintext  (pt[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses key_load and counts cycles until core 0 reports key_ready.
  task automatic load_key(input logic [127:0] k);
    key      = k;
    key_load = 1'b1;
    tick();
    key_load  = 1'b0;
    key_lat   = 0;
    saw_ready = 1'b0;
    while (key_ready_v[0] == 1'b0 && key_lat < 40) begin
      if (in_ready_v != 5'b0) saw_ready = 1'b1;
      tick();
      key_lat++;
    end
  endtask

  // Takes the accept edge, then records each core's latency and plaintext.
  task automatic finish_block();
    tick();
    in_valid = 1'b0;
    iv_load  = 1'b0;
    for (int d = 0; d < 5; d++) begin
      lat[d] = -1;
      got[d] = '0;
    end
    for (int c = 1; c <= 12; c++) begin
      tick();
      for (int d = 0; d < 5; d++)
        if (out_valid_v[d] && lat[d] < 0) begin
          lat[d] = c;
          got[d] = pt[d];
        end
    end
  endtask

  task automatic block_all(input logic [127:0] ct, input logic ld_iv, input logic [127:0] ivv);
    ciphertext = ct;
    in_valid   = 1'b1;
    iv_load    = ld_iv;
    iv         = ivv;
    finish_block();
  endtask

  initial begin
    int cnt;
    int n_pt_bad;
    int n_ctl_bad;

    rst = 1'b1; key_load = 1'b0; key = '0; iv_load = 1'b0; iv = '0;
    in_valid = 1'b0; ciphertext = '0; out_ready = 1'b1;
    tick(); tick();
    check("rst_key_ready", key_ready_v, 5'b0);
    check("rst_in_ready", in_ready_v, 5'b0);
    check("rst_out_valid", out_valid_v, 5'b0);
    check("rst_plaintext", pt[0], 128'h0);
    rst = 1'b0;
    in_valid = 1'b1;
    tick(); tick();
    check("key_idle_in_ready", in_ready_v, 5'b0);
    in_valid = 1'b0;

    // FIPS-197 C.1 with in_valid raised during expansion.
    ciphertext = CT_C1;
    in_valid   = 1'b1;
    load_key(KEY_C1);
    check("c1_key_latency", key_lat, 10);
    check("expand_in_ready", saw_ready, 1'b0);
    finish_block();
    check("c1_latency_u1", lat[0], 10);
    check("c1_pt_u1", got[0], PT_C1);
    check("c1_pt_u10", got[3], PT_C1);
    check("c1_pt_cbc_zero_chain", got[4], PT_C1);

    // FIPS-197 B across all unroll factors.
    load_key(KEY_B);
    check("b_key_latency", key_lat, 10);
    block_all(CT_B, 1'b0, '0);
    check("b_pt_u1", got[0], PT_B);
    check("b_latency_u2", lat[1], 5);
    check("b_pt_u2", got[1], PT_B);
    check("b_latency_u5", lat[2], 2);
    check("b_pt_u5", got[2], PT_B);
    check("b_latency_u10", lat[3], 1);
    check("b_pt_u10", got[3], PT_B);

    // SP800-38A CBC, IV loaded in the accept cycle of the first block.
    block_all(CT_F1, 1'b1, IV_F);
    check("cbc_latency_1", lat[4], 10);
    check("cbc_pt_1", got[4], PT_F1);
    block_all(CT_F2, 1'b0, '0);
    check("cbc_pt_2", got[4], PT_F2);

    // Back-pressure: DONE holds while a key_load and a new block are offered.
    out_ready  = 1'b0;
    ciphertext = CT_B;
    in_valid   = 1'b1;
    tick();
    ciphertext = CT_C1;
    cnt = 0;
    while (!out_valid_v[0] && cnt < 20) begin
      tick();
      cnt++;
    end
    check("bp_latency", cnt, 10);
    check("bp_pt", pt[0], PT_B);
    n_pt_bad  = 0;
    n_ctl_bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin key = KEY_C1; key_load = 1'b1; end
      if (i == 6) key_load = 1'b0;
      tick();
      if (pt[0] !== PT_B) n_pt_bad++;
      if (out_valid_v !== 5'b11111 || in_ready_v !== 5'b0) n_ctl_bad++;
    end
    check("bp_pt_stable", n_pt_bad, 0);
    check("bp_ctl_stable", n_ctl_bad, 0);
    check("bp_key_ready", key_ready_v, 5'b11111);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_out_valid", out_valid_v, 5'b0);
    block_all(CT_B, 1'b0, '0);
    check("bp_old_key_u1", got[0], PT_B);
    check("bp_old_key_u5", got[2], PT_B);

    // Asynchronous reset in the middle of RUN.
    ciphertext = CT_B;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    check("arst_key_ready", key_ready_v, 5'b0);
    check("arst_in_ready", in_ready_v, 5'b0);
    check("arst_out_valid", out_valid_v, 5'b0);
    check("arst_plaintext", pt[0], 128'h0);
    tick();
    rst = 1'b0;
    tick(); tick(); tick();
    check("arst_no_key_in_ready", in_ready_v, 5'b0);
    load_key(KEY_C1);
    check("arst_key_latency", key_lat, 10);
    check("arst_expand_in_ready", saw_ready, 1'b0);
    block_all(CT_C1, 1'b0, '0);
    check("arst_c1_latency", lat[0], 10);
    check("arst_c1_pt", got[0], PT_C1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
